// File: rtl/fc_pkg.sv
// fc_pkg: width derivations and FSM states shared by the fully-connected layer buffers.
package fc_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCUM = 2'd1, ST_DRAIN = 2'd2} fc_state_e;
  function automatic int fc_adc_width(int d, int x);
    return d + $clog2(x);
  endfunction
  function automatic int fc_obuf_data_size(int d, int x);
    return d == 1 ? $clog2(x) : 2 * d + $clog2(x);
  endfunction
  function automatic int fc_num_channels(int d, int x, int bus);
    return bus / fc_obuf_data_size(d, x);
  endfunction
  function automatic int fc_fifo_length(int d, int x, int bus);
    int n = fc_num_channels(d, x, bus);
    return (x / d + n - 1) / n;
  endfunction
endpackage

// File: rtl/fc_requant.sv
// fc_requant: shifts an accumulated sum down and saturates it to the output width.
module fc_requant #(
  parameter int IN_W = 23,
  parameter int OUT_W = 8,
  parameter int SHIFT = 15
) (
  input  logic [IN_W-1:0]  i_acc,
  output logic [OUT_W-1:0] o_q
);
  logic [IN_W-1:0] w_sh;
  assign w_sh = i_acc >> SHIFT;
  assign o_q = |w_sh[IN_W-1:OUT_W] ? '1 : w_sh[OUT_W-1:0];
endmodule

// File: rtl/fc_obuf.sv
// fc_obuf: accumulates bit-serial crossbar partial sums per output slot, then requantises
// and drains the slots to the next layer's input buffer.
module fc_obuf
  import fc_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int XBAR_SIZE = 128,
  parameter int OBUF_BUS_WIDTH = 46,
  parameter int QUANT_SHIFT = DATA_SIZE + $clog2(XBAR_SIZE),
  localparam int ADC_WIDTH = fc_adc_width(DATA_SIZE, XBAR_SIZE),
  localparam int ACC_WIDTH = ADC_WIDTH + DATA_SIZE,
  localparam int NUM_CHANNELS = fc_num_channels(DATA_SIZE, XBAR_SIZE, OBUF_BUS_WIDTH),
  localparam int FIFO_LENGTH = fc_fifo_length(DATA_SIZE, XBAR_SIZE, OBUF_BUS_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_adc_valid,
  input  logic [NUM_CHANNELS*ADC_WIDTH-1:0] i_adc_data,
  output logic                              o_adc_ready,
  output logic                              o_we,
  output logic [NUM_CHANNELS*DATA_SIZE-1:0] o_data,
  input  logic                              i_ready,
  output logic                              o_done,
  output logic                              o_err
);
  localparam int EW = FIFO_LENGTH > 1 ? $clog2(FIFO_LENGTH) : 1;
  localparam int BW = DATA_SIZE > 1 ? $clog2(DATA_SIZE) : 1;
  localparam logic [EW-1:0] E_LAST = EW'(FIFO_LENGTH - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_SIZE - 1);
  fc_state_e r_state;
  logic [EW-1:0] r_elem;
  logic [BW-1:0] r_bit;
  logic [ACC_WIDTH-1:0] r_acc [FIFO_LENGTH][NUM_CHANNELS];
  logic r_done, r_err;
  logic w_take, w_last, w_xfer, w_wrap;
  logic [EW-1:0] w_slot;
  assign o_adc_ready = r_state != ST_DRAIN;
  assign o_we = r_state == ST_DRAIN;
  assign o_done = r_done;
  assign o_err = r_err;
  assign w_take = i_adc_valid && o_adc_ready;
  assign w_xfer = o_we && i_ready;
  assign w_wrap = r_elem == E_LAST;
  assign w_last = w_wrap && r_bit == B_LAST;
  // r_elem counts up during drain too; slots leave highest-first
  assign w_slot = E_LAST - r_elem;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_elem <= '0;
      r_bit <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      for (int k = 0; k < FIFO_LENGTH; k++)
        for (int j = 0; j < NUM_CHANNELS; j++) r_acc[k][j] <= '0;
    end else begin
      r_done <= w_xfer && w_wrap;
      if (i_adc_valid && !o_adc_ready) r_err <= 1'b1;
      if (w_take) begin
        for (int j = 0; j < NUM_CHANNELS; j++)
          r_acc[r_elem][j] <= (r_bit == '0 ? '0 : r_acc[r_elem][j])
                              + (ACC_WIDTH'(i_adc_data[j*ADC_WIDTH +: ADC_WIDTH]) << r_bit);
        r_state <= w_last ? ST_DRAIN : ST_ACCUM;
        r_elem <= w_wrap ? '0 : r_elem + 1'b1;
        r_bit <= w_last ? '0 : w_wrap ? r_bit + 1'b1 : r_bit;
      end else if (w_xfer) begin
        r_elem <= w_wrap ? '0 : r_elem + 1'b1;
        r_state <= w_wrap ? ST_IDLE : ST_DRAIN;
      end
    end
  end
  for (genvar j = 0; j < NUM_CHANNELS; j++) begin : g_rq
    fc_requant #(.IN_W(ACC_WIDTH), .OUT_W(DATA_SIZE), .SHIFT(QUANT_SHIFT)) u_rq (
      .i_acc(r_acc[w_slot][j]),
      .o_q  (o_data[j*DATA_SIZE +: DATA_SIZE])
    );
  end
endmodule

// File: tb/tb_fc_obuf.sv
// tb_fc_obuf: random and directed ADC streams checked against a per-beat sum model,
// with a second instance using QUANT_SHIFT=8 to exercise saturation.
module tb_fc_obuf;
  localparam int D = 8, FL = 8, NC = 2, AW = 15;
  logic clk = 0, rst_n = 0, i_adc_valid = 0, i_ready = 0;
  logic [NC*AW-1:0] i_adc_data = '0;
  logic o_adc_ready, o_we, o_done, o_err;
  logic o_adc_ready5, o_we5, o_done5, o_err5;
  logic [NC*D-1:0] o_data, o_data5;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  fc_obuf dut (
    .clk(clk), .rst_n(rst_n), .i_adc_valid(i_adc_valid), .i_adc_data(i_adc_data),
    .o_adc_ready(o_adc_ready), .o_we(o_we), .o_data(o_data), .i_ready(i_ready),
    .o_done(o_done), .o_err(o_err)
  );
  fc_obuf #(.QUANT_SHIFT(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .i_adc_valid(i_adc_valid), .i_adc_data(i_adc_data),
    .o_adc_ready(o_adc_ready5), .o_we(o_we5), .o_data(o_data5), .i_ready(i_ready),
    .o_done(o_done5), .o_err(o_err5)
  );
  int unsigned m_beat [FL*D][NC];
  bit m_drain = 0, m_done = 0, m_err = 0, m_on = 0;
  int m_n = 0, m_d = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // value of slot k, channel j = sum over planes of beat << plane, then shift and clamp
  function automatic longint exp_q(int k, int j, int sh);
    longint v = 0;
    for (int b = 0; b < D; b++) v += longint'(m_beat[b*FL+k][j]) << b;
    v = v >> sh;
    return v > 255 ? 255 : v;
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1; m_drain = 0; m_done = 0; m_err = 0; m_n = 0; m_d = 0;
      foreach (m_beat[n, j]) m_beat[n][j] = 0;
    end else begin
      m_done = 0;
      if (m_drain) begin
        if (i_adc_valid) m_err = 1;
        if (i_ready) begin
          m_d++;
          if (m_d == FL) begin m_drain = 0; m_done = 1; m_n = 0; m_d = 0; end
        end
      end else if (i_adc_valid) begin
        for (int j = 0; j < NC; j++) m_beat[m_n][j] = i_adc_data[j*AW +: AW];
        m_n++;
        if (m_n == FL * D) m_drain = 1;
      end
    end
  end
  always @(negedge clk) if (m_on) begin
    chk("adc_ready", o_adc_ready, !m_drain);
    chk("we", o_we, m_drain);
    chk("we5", o_we5, m_drain);
    chk("done", o_done, m_done);
    chk("err", o_err, m_err);
    if (m_drain)
      for (int j = 0; j < NC; j++) begin
        chk("data", o_data[j*D +: D], exp_q(FL - 1 - m_d, j, 15));
        chk("data5", o_data5[j*D +: D], exp_q(FL - 1 - m_d, j, 8));
      end
  end
  function automatic int unsigned beat_val(int mode, int b);
    case (mode)
      0: return b == D - 1 ? 16384 : 0;
      1: return 32767;
      2: return 1024;
      default: return $urandom_range(0, 32767);
    endcase
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; i_adc_valid = 0; i_ready = 0;
    @(negedge clk);
    chk("rst_we", o_we, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_data", o_data, 0);
    chk("rst_data5", o_data5, 0);
    chk("rst_ready", o_adc_ready, 1);
    rst_n = 1;
  endtask
  task automatic feed(input int mode, input int nbeats, input bit gaps);
    for (int n = 0; n < nbeats; n++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin i_adc_valid = 0; @(negedge clk); end
      i_adc_valid = 1;
      for (int j = 0; j < NC; j++) i_adc_data[j*AW +: AW] = AW'(beat_val(mode, n / FL));
      @(negedge clk);
    end
    i_adc_valid = 0;
  endtask
  task automatic drain(input int lit, input int lit5, input int stall_at, input int stall_len, input bit poke);
    int xf = 0, cyc = 0, st = 0, dn = 0;
    logic [NC*D-1:0] held = '0;
    chk("latency", o_we, 1);
    while (xf < FL && cyc < 100) begin
      i_adc_valid = poke && cyc == 1;
      if (poke && cyc == 1) i_adc_data = (NC*AW)'($urandom);
      if (o_done) dn++;
      if (o_we) begin
        for (int j = 0; j < NC; j++) begin
          if (lit >= 0) chk("lit", o_data[j*D +: D], lit);
          if (lit5 >= 0) chk("lit5", o_data5[j*D +: D], lit5);
        end
        if (st > 0 && xf == stall_at) chk("hold", o_data, held);
        if (xf == stall_at && st < stall_len) begin held = o_data; i_ready = 0; st++; end
        else begin i_ready = 1; xf++; end
      end
      @(negedge clk);
      cyc++;
    end
    i_adc_valid = 0;
    if (cyc >= 100) chk("drain_timeout", xf, FL);
    chk("done_pulse", o_done, 1);
    chk("we_off", o_we, 0);
    chk("early_done", dn, 0);
    @(negedge clk);
    chk("done_once", o_done, 0);
    i_ready = 0;
  endtask
  initial begin
    do_reset();
    feed(0, 64, 0); drain(64, 255, -1, 0, 0);
    feed(1, 64, 1); drain(254, 255, -1, 0, 0);
    feed(0, 64, 0); drain(64, 255, 1, 3, 0);
    feed(1, 64, 0); drain(254, 255, -1, 0, 1);
    chk("err_sticky", o_err, 1);
    do_reset();
    feed(2, 64, 0); drain(7, 255, -1, 0, 0);
    repeat (6) begin
      feed(3, 64, 1);
      drain(-1, -1, $urandom_range(0, 7), $urandom_range(0, 4), 0);
    end
    feed(3, 20, 1);
    do_reset();
    feed(0, 64, 0); drain(64, 255, -1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fc_obuf.md
FC_OBUF -- requirements
Module: fc_obuf

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, meaning activation/weight bit width and number of bit-planes per inference.
REQ-002 SHALL have parameter XBAR_SIZE, default 128, meaning crossbar rows summed per ADC sample.
REQ-003 SHALL have parameter OBUF_BUS_WIDTH, default 46, meaning the total bus width toward the next layer.
REQ-004 SHALL have parameter QUANT_SHIFT, default DATA_SIZE+$clog2(XBAR_SIZE), meaning the right shift applied before requantisation.
REQ-005 SHALL derive ADC_WIDTH=DATA_SIZE+$clog2(XBAR_SIZE), ACC_WIDTH=ADC_WIDTH+DATA_SIZE, OBUF_DATA_SIZE (DATA_SIZE==1 ? $clog2(XBAR_SIZE) : 2*DATA_SIZE+$clog2(XBAR_SIZE)), NUM_CHANNELS=floor(OBUF_BUS_WIDTH/OBUF_DATA_SIZE) and FIFO_LENGTH=ceil(floor(XBAR_SIZE/DATA_SIZE)/NUM_CHANNELS).
REQ-006 SHALL use one clock; reset is synchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 i_adc_valid  input  1  ADC beat present.
REQ-010 i_adc_data  input  [ADC_WIDTH-1:0] x NUM_CHANNELS  unsigned partial sums for one element slot.
REQ-011 o_adc_ready  output  1  block accepts ADC beats.
REQ-012 o_we  output  1  write strobe toward the next layer's input buffer.
REQ-013 o_data  output  [DATA_SIZE-1:0] x NUM_CHANNELS  requantised outputs.
REQ-014 i_ready  input  1  downstream accepts the current o_we beat.
REQ-015 o_done  output  1  one-cycle pulse after the last drain beat.
REQ-016 o_err  output  1  sticky flag: ADC beat received while o_adc_ready=0.

Function
REQ-017 SHALL implement FSM IDLE, ACCUM, DRAIN; o_adc_ready=1 in IDLE and ACCUM, 0 in DRAIN.
REQ-018 SHALL hold acc[k][j] (k<FIFO_LENGTH, j<NUM_CHANNELS), each ACC_WIDTH bits, unsigned.
REQ-019 SHALL keep elem_cnt (0..FIFO_LENGTH-1) and bit_cnt (0..DATA_SIZE-1); each accepted beat targets slot k=elem_cnt at bit-plane b=bit_cnt.
REQ-020 Accepted beat SHALL do acc[k][j] <= (b==0 ? 0 : acc[k][j]) + (i_adc_data[j] << b), where plane 0 is the LSB plane (matching LSB-first input shifting).
REQ-021 elem_cnt SHALL wrap to 0 after FIFO_LENGTH-1 and increment bit_cnt; IDLE->ACCUM on the first accepted beat.
REQ-022 On the beat with elem_cnt=FIFO_LENGTH-1 and bit_cnt=DATA_SIZE-1, SHALL go to DRAIN with both counters 0 the next cycle.
REQ-023 In DRAIN, o_we=1; o_data[j]=sat(acc[k][j]>>QUANT_SHIFT) with sat clamping to 2^DATA_SIZE-1; slot order k=FIFO_LENGTH-1 down to 0 so the shift-in buffer ends with slot k at index k.
REQ-024 A beat SHALL transfer only when o_we&&i_ready; o_data SHALL stay stable while i_ready=0.
REQ-025 After the slot-0 transfer, SHALL go to IDLE, pulse o_done for one cycle, and deassert o_we.
REQ-026 i_adc_valid while o_adc_ready=0 SHALL be dropped and SHALL set o_err until reset.
REQ-027 Output latency: first o_we SHALL assert in the cycle after the final ADC beat is accepted.

Reset
REQ-028 rst_n=0 at any clock edge, including mid-ACCUM or mid-DRAIN, SHALL force IDLE, clear counters and accumulators, and drive o_we=0, o_done=0, o_err=0, o_data=0, o_adc_ready=1 in the following cycle.

Structure
REQ-029 The derived-width functions and the FSM state enum SHALL live in the shared fc package used by the FC buffers.
REQ-030 Requantisation (shift plus saturate) SHALL be one sub-module, fc_requant, instantiated NUM_CHANNELS times.

Verification
REQ-031 Use defaults for scenarios 1-4 (NUM_CHANNELS=2, FIFO_LENGTH=8, ADC_WIDTH=15, QUANT_SHIFT=15).
1. ADC=16384 on plane 7 only, 0 elsewhere, all slots -> 8 beats, every o_data=64, then o_done.
2. ADC=32767 on all 64 beats -> every o_data=254.
3. i_ready low for 3 cycles on the 2nd drain beat -> o_data held, 8 transfers total, o_done once.
4. i_adc_valid during DRAIN -> beat ignored, o_err=1, outputs unaffected.
5. Override QUANT_SHIFT=8, ADC=1024 on all beats -> every o_data=255 (saturated).
6. rst_n low mid-ACCUM, then repeat scenario 1 -> identical result, no stale accumulation.
